// File: rtl/fft_job_ctrl.sv
// fft_job_ctrl: runs one N-point FFT job: streams N source samples into the core, then collects N results into the destination.
// Latency: src_rd -> fft_in_valid 2 cycles; fft_out_valid -> dst_wr 1 cycle; done 1 cycle after the count reaches N.
// Backpressure: none; the feed is gapless, every core result is accepted, and the drain aborts after DRAIN_TIMEOUT idle cycles.
module fft_job_ctrl #(
    parameter int FLOAT_PRECISION = 64,
    parameter int logn            = 8,
    parameter int DRAIN_TIMEOUT   = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err_timeout,
    output logic                       src_rd,
    output logic [logn-1:0]            src_addr,
    input  logic [FLOAT_PRECISION-1:0] src_re,
    input  logic [FLOAT_PRECISION-1:0] src_im,
    output logic                       fft_in_valid,
    output logic [FLOAT_PRECISION-1:0] fft_fi_re,
    output logic [FLOAT_PRECISION-1:0] fft_fi_im,
    input  logic                       fft_out_valid,
    input  logic [FLOAT_PRECISION-1:0] fft_fo_re,
    input  logic [FLOAT_PRECISION-1:0] fft_fo_im,
    output logic                       dst_wr,
    output logic [logn-1:0]            dst_addr,
    output logic [FLOAT_PRECISION-1:0] dst_re,
    output logic [FLOAT_PRECISION-1:0] dst_im
);

    localparam int CW = logn + 1;
    localparam int TW = $clog2(DRAIN_TIMEOUT) + 1;
    localparam logic [CW-1:0] N_CNT   = CW'(1 << logn);
    localparam logic [TW-1:0] TO_LAST = TW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] rd_cnt;   // reads issued in this job
    logic [CW-1:0] wr_cnt;   // results written in this job
    logic [TW-1:0] to_cnt;   // consecutive result-less drain cycles
    logic          rd_d1;    // src_rd delayed one cycle: source data valid now
    logic          accept_res;
    logic          job_start;

    // A job starts only when start is seen in IDLE; anything else is dropped.
    assign job_start  = (state == S_IDLE) && start;

    // Results count while the job is live (FEED overlaps core latency) and only until N arrived.
    assign accept_res = fft_out_valid && ((state == S_FEED) || (state == S_DRAIN)) && (wr_cnt < N_CNT);

    // Job sequencer: read issue, drain completion / timeout, and the status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            src_rd      <= 1'b0;
            src_addr    <= '0;
            rd_cnt      <= '0;
            to_cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done        <= 1'b0;
                    err_timeout <= 1'b0;
                    if (start) begin
                        // First read goes out in the first FEED cycle.
                        state    <= S_FEED;
                        busy     <= 1'b1;
                        src_rd   <= 1'b1;
                        src_addr <= '0;
                        rd_cnt   <= CW'(1);
                        to_cnt   <= '0;
                    end
                end
                S_FEED: begin
                    if (rd_cnt == N_CNT) begin
                        // The cycle just ending carried address N-1.
                        state  <= S_DRAIN;
                        src_rd <= 1'b0;
                        to_cnt <= '0;
                    end else begin
                        src_rd   <= 1'b1;
                        src_addr <= rd_cnt[logn-1:0];
                        rd_cnt   <= rd_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (wr_cnt == N_CNT) begin
                        state       <= S_DONE;
                        done        <= 1'b1;
                        err_timeout <= 1'b0;
                    end else if (fft_out_valid) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        // This idle cycle brings the count to DRAIN_TIMEOUT: abort.
                        state       <= S_DONE;
                        done        <= 1'b1;
                        err_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    busy        <= 1'b0;
                    done        <= 1'b0;
                    err_timeout <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Input path: align the one-cycle-late source data with a two-cycle-delayed valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_d1        <= 1'b0;
            fft_in_valid <= 1'b0;
            fft_fi_re    <= '0;
            fft_fi_im    <= '0;
        end else begin
            rd_d1        <= src_rd;
            fft_in_valid <= rd_d1;
            if (rd_d1) begin
                fft_fi_re <= src_re;
                fft_fi_im <= src_im;
            end
        end
    end

    // Output path: register each accepted result and write it at its arrival index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_wr   <= 1'b0;
            dst_addr <= '0;
            dst_re   <= '0;
            dst_im   <= '0;
            wr_cnt   <= '0;
        end else begin
            dst_wr <= 1'b0;
            if (job_start) begin
                wr_cnt <= '0;
            end else if (accept_res) begin
                dst_wr   <= 1'b1;
                dst_addr <= wr_cnt[logn-1:0];
                dst_re   <= fft_fo_re;
                dst_im   <= fft_fo_im;
                wr_cnt   <= wr_cnt + CW'(1);
            end
        end
    end

endmodule
